lut_cfg_bank: RTL

- Bank of NUM_LUT independent K-input lookup tables. Each LUT's truth-table mask is held in registers and can be reloaded at runtime through a narrow valid/ready configuration port.
- A new mask is assembled in a shadow register and committed atomically, so a LUT output never reflects a partially loaded function.
- Used wherever the fabric model needs soft-reconfigurable logic cells in place of fixed-mask LUT primitives.

---
 rtl/lut_cfg_bank_if.sv | 25 ++
 rtl/lut_cfg_bank.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lut_cfg_bank_if.sv
// Configuration port of lut_cfg_bank: start/abort control, valid/ready beat
// transfer and done/err status pulses.
interface lut_cfg_bank_if #(
  parameter int IDX_W = 2,
  parameter int CFG_W = 8
) ();
  logic             cfg_start;
  logic [IDX_W-1:0] cfg_lut_idx;
  logic             cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             cfg_abort;
  logic             cfg_done;
  logic             cfg_err;

  modport master (
    output cfg_start, cfg_lut_idx, cfg_valid, cfg_data, cfg_abort,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_start, cfg_lut_idx, cfg_valid, cfg_data, cfg_abort,
    output cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/lut_cfg_bank.sv
// Bank of NUM_LUT K-input LUTs whose masks are reloaded beat-by-beat into a
// shadow register and committed atomically into the selected LUT.
module lut_cfg_bank #(
  parameter int               NUM_LUT   = 4,
  parameter int               K         = 4,
  parameter int               CFG_W     = 8,
  parameter bit               REG_OUT   = 1'b1,
  parameter logic [(1<<K)-1:0] INIT_MASK = '1,
  parameter int               IDX_W     = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LUT*K-1:0] din,
  output logic [NUM_LUT-1:0]   dout,
  lut_cfg_bank_if.slave        cfg
);
  localparam int M     = 1 << K;
  localparam int BEATS = M / CFG_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [IDX_W:0]   NUM_LUT_V = (IDX_W+1)'(NUM_LUT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [M-1:0]       r_mask [NUM_LUT];
  logic [M-1:0]       r_shadow;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_err;
  logic               w_idx_ok, w_start_ok, w_start_bad, w_beat, w_commit;
  logic               w_ready, w_done;
  logic [NUM_LUT-1:0] w_lut;

  assign w_idx_ok = {1'b0, cfg.cfg_lut_idx} < NUM_LUT_V;

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_beat      = 1'b0;
    w_commit    = 1'b0;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg.cfg_start) begin
          if (w_idx_ok) begin
            w_start_ok  = 1'b1;
            w_state_nxt = S_LOAD;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (cfg.cfg_abort) begin
          w_state_nxt = S_IDLE;
        end else if (cfg.cfg_valid) begin
          w_beat = 1'b1;
          if (r_cnt == LAST_BEAT) w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_done      = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_start_bad;
      if (w_start_ok) begin
        r_idx    <= cfg.cfg_lut_idx;
        r_cnt    <= '0;
        r_shadow <= '0;
      end else if (w_beat) begin
        for (int b = 0; b < BEATS; b++) begin
          if (r_cnt == CNT_W'(b)) r_shadow[b*CFG_W +: CFG_W] <= cfg.cfg_data;
        end
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // NOTE: the mask bank is reset rather than left undefined because the LUT
  // function must be known from the first cycle after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LUT; i++) begin
      if (!rst_n) begin
        r_mask[i] <= INIT_MASK;
      end else if (w_commit && (r_idx == IDX_W'(i))) begin
        r_mask[i] <= r_shadow;
      end
    end
  end

  always_comb begin
    w_lut = '0;
    for (int i = 0; i < NUM_LUT; i++) begin
      w_lut[i] = r_mask[i][din[i*K +: K]];
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [NUM_LUT-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (!rst_n) r_dout <= '0;
        else        r_dout <= w_lut;
      end
      assign dout = r_dout;
    end else begin : g_comb_out
      assign dout = w_lut;
    end
  endgenerate

  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_done  = w_done;
  assign cfg.cfg_err   = r_err;
endmodule
